// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: turns divider levels into one-cycle ticks, runs the
// IDLE/RUN/PAUSE/ADJUST FSM, keeps the BCD mm:ss count and drives digit scanning.
module stopwatch_ctrl #(
  parameter int MIN_MAX  = 59,   // decimal value of the last minute, at most 99
  parameter bit BLINK_EN = 1'b1
) (
  input  logic        clk_sc,
  input  logic        rst_n_sc,
  input  logic        clk_1hz_sc,
  input  logic        clk_2hz_sc,
  input  logic        clk_500hz_sc,
  input  logic        btn_pause_sc,
  input  logic        btn_reset_sc,
  input  logic        sw_adj_sc,
  input  logic        sw_sel_sc,
  output logic [3:0]  an_sc,
  output logic [3:0]  digit_sc,
  output logic [15:0] count_sc,
  output logic [1:0]  state_sc
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSE  = 2'b10,
    ADJUST = 2'b11
  } state_t;

  localparam logic [7:0] MIN_LAST = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10)};

  logic [4:0]  edge_in;
  logic [4:0]  edge_q;
  logic [4:0]  pulse_reg;
  logic        tick_1hz;
  logic        tick_2hz;
  logic        tick_500hz;
  logic        tick_pause;
  logic        tick_reset;

  state_t      state_reg;
  state_t      state_next;
  logic [15:0] count_reg;
  logic [15:0] count_next;
  logic        blink_reg;
  logic        blink_next;
  logic [1:0]  idx_reg;
  logic [1:0]  idx_next;
  logic [3:0]  an_reg;
  logic [3:0]  an_next;
  logic [3:0]  digit_reg;
  logic [3:0]  digit_next;
  logic [3:0]  scan_digit;
  logic        blank;

  assign edge_in = {btn_reset_sc, btn_pause_sc, clk_500hz_sc, clk_2hz_sc, clk_1hz_sc};

  // Registered rising-edge pulses, valid the cycle after the input rises
  always_ff @(posedge clk_sc or negedge rst_n_sc) begin
    if (!rst_n_sc) begin
      edge_q    <= '0;
      pulse_reg <= '0;
    end else begin
      edge_q    <= edge_in;
      pulse_reg <= edge_in & ~edge_q;
    end
  end

  assign tick_1hz   = pulse_reg[0];
  assign tick_2hz   = pulse_reg[1];
  assign tick_500hz = pulse_reg[2];
  assign tick_pause = pulse_reg[3];
  assign tick_reset = pulse_reg[4];

  function automatic logic [7:0] inc_sec(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h59)
      r = 8'h00;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] inc_min(input logic [7:0] v);
    logic [7:0] r;
    if (v == MIN_LAST)
      r = 8'h00;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  always_ff @(posedge clk_sc or negedge rst_n_sc) begin
    if (!rst_n_sc)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (tick_reset)
      state_next = IDLE;
    else if (sw_adj_sc)
      state_next = ADJUST;
    else if (state_reg == ADJUST)
      state_next = PAUSE;
    else if (tick_pause) begin
      case (state_reg)
        IDLE, PAUSE: state_next = RUN;
        RUN:         state_next = PAUSE;
        default:     state_next = state_reg;
      endcase
    end
  end

  always_comb begin
    count_next = count_reg;
    blink_next = blink_reg;
    idx_next   = idx_reg;
    an_next    = an_reg;
    digit_next = digit_reg;

    // Counting and adjusting both act on the registered state
    if (tick_reset)
      count_next = '0;
    else if (state_reg == RUN && tick_1hz) begin
      count_next[7:0] = inc_sec(count_reg[7:0]);
      if (count_reg[7:0] == 8'h59)
        count_next[15:8] = inc_min(count_reg[15:8]);
    end else if (state_reg == ADJUST && tick_2hz) begin
      if (sw_sel_sc)
        count_next[15:8] = inc_min(count_reg[15:8]);
      else
        count_next[7:0] = inc_sec(count_reg[7:0]);
    end

    if (state_next != ADJUST)
      blink_next = 1'b0;
    else if (state_reg == ADJUST && tick_2hz)
      blink_next = ~blink_reg;

    case (idx_reg)
      2'd0:    scan_digit = count_reg[3:0];
      2'd1:    scan_digit = count_reg[7:4];
      2'd2:    scan_digit = count_reg[11:8];
      default: scan_digit = count_reg[15:12];
    endcase

    // idx 2/3 are the minute digits, idx 0/1 the second digits
    blank = BLINK_EN && (state_reg == ADJUST) && blink_reg && (idx_reg[1] == sw_sel_sc);

    if (tick_500hz) begin
      idx_next   = idx_reg + 2'd1;
      an_next    = blank ? 4'b1111 : ~(4'b0001 << idx_reg);
      digit_next = scan_digit;
    end
  end

  always_ff @(posedge clk_sc or negedge rst_n_sc) begin
    if (!rst_n_sc) begin
      count_reg <= '0;
      blink_reg <= 1'b0;
      idx_reg   <= 2'd0;
      an_reg    <= 4'b1111;
      digit_reg <= 4'd0;
    end else begin
      count_reg <= count_next;
      blink_reg <= blink_next;
      idx_reg   <= idx_next;
      an_reg    <= an_next;
      digit_reg <= digit_next;
    end
  end

  assign an_sc    = an_reg;
  assign digit_sc = digit_reg;
  assign count_sc = count_reg;
  assign state_sc = state_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random stimulus, checked every
// cycle against a seconds-based behavioural model.
module tb_stopwatch_ctrl;

  localparam int MIN_MAX  = 59;
  localparam bit BLINK_EN = 1'b1;

  localparam logic [4:0] B1HZ   = 5'b00001;
  localparam logic [4:0] B2HZ   = 5'b00010;
  localparam logic [4:0] B500   = 5'b00100;
  localparam logic [4:0] BPAUSE = 5'b01000;
  localparam logic [4:0] BRST   = 5'b10000;

  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_ADJ = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  ins = '0;
  logic        sw_adj = 1'b0;
  logic        sw_sel = 1'b0;
  logic [3:0]  an;
  logic [3:0]  digit;
  logic [15:0] count;
  logic [1:0]  state;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.MIN_MAX(MIN_MAX), .BLINK_EN(BLINK_EN)) dut (
    .clk_sc      (clk),
    .rst_n_sc    (rst_n),
    .clk_1hz_sc  (ins[0]),
    .clk_2hz_sc  (ins[1]),
    .clk_500hz_sc(ins[2]),
    .btn_pause_sc(ins[3]),
    .btn_reset_sc(ins[4]),
    .sw_adj_sc   (sw_adj),
    .sw_sel_sc   (sw_sel),
    .an_sc       (an),
    .digit_sc    (digit),
    .count_sc    (count),
    .state_sc    (state)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: time kept as minutes and seconds integers
  int         m_min, m_sec, m_st, m_idx;
  bit         m_blink;
  logic [3:0] m_an, m_dig;
  logic [4:0] m_prev, m_pend;

  function automatic logic [15:0] bcd(input int mi, input int s);
    return {4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic model_reset();
    m_min = 0; m_sec = 0; m_st = S_IDLE; m_idx = 0; m_blink = 0;
    m_an = 4'b1111; m_dig = 4'd0; m_prev = '0; m_pend = '0;
  endtask

  task automatic model_step();
    logic [4:0] p;
    logic [3:0] one;
    int old_st, t, d;
    bit blank;
    p = m_pend;
    old_st = m_st;
    one = 4'b0001;
    if (p[2]) begin
      case (m_idx)
        0: d = m_sec % 10;
        1: d = m_sec / 10;
        2: d = m_min % 10;
        default: d = m_min / 10;
      endcase
      blank = BLINK_EN && old_st == S_ADJ && m_blink && ((m_idx >= 2) == sw_sel);
      m_an  = blank ? 4'b1111 : ~(one << m_idx);
      m_dig = 4'(d);
      m_idx = (m_idx + 1) % 4;
    end
    if (p[4]) begin
      m_min = 0; m_sec = 0;
    end else if (old_st == S_RUN && p[0]) begin
      t = (m_min * 60 + m_sec + 1) % ((MIN_MAX + 1) * 60);
      m_min = t / 60; m_sec = t % 60;
    end else if (old_st == S_ADJ && p[1]) begin
      if (sw_sel) m_min = (m_min + 1) % (MIN_MAX + 1);
      else        m_sec = (m_sec + 1) % 60;
    end
    if (p[4])                  m_st = S_IDLE;
    else if (sw_adj)           m_st = S_ADJ;
    else if (old_st == S_ADJ)  m_st = S_PAUSE;
    else if (p[3])             m_st = (old_st == S_RUN) ? S_PAUSE : S_RUN;
    if (m_st != S_ADJ)                  m_blink = 0;
    else if (old_st == S_ADJ && p[1])   m_blink = ~m_blink;
    m_pend = ins & ~m_prev;
    m_prev = ins;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst_n) model_step();
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("an", {12'd0, an}, {12'd0, m_an});
        check("digit", {12'd0, digit}, {12'd0, m_dig});
        check("count", count, bcd(m_min, m_sec));
        check("state", {14'd0, state}, 16'(m_st));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, fails so far %0d", fails);
    $fatal(1, "watchdog expired");
  end

  task automatic pulse(input logic [4:0] m);
    ins = ins | m;
    @(negedge clk);
    ins = ins & ~m;
    @(negedge clk);
  endtask

  task automatic adjust_to(input int mi, input int s);
    pulse(BRST);
    sw_adj = 1'b1;
    @(negedge clk);
    sw_sel = 1'b1;
    repeat (mi) pulse(B2HZ);
    sw_sel = 1'b0;
    repeat (s) pulse(B2HZ);
    sw_adj = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  logic [3:0] an_tbl [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  int blanks;

  initial begin
    // T1 reset behaviour
    repeat (3) @(negedge clk);
    check("t1_hold_an", {12'd0, an}, 16'h000F);
    check("t1_hold_count", count, 16'h0000);
    check("t1_hold_state", {14'd0, state}, 16'h0000);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("t1_release_an", {12'd0, an}, 16'h000F);
    pulse(B500);
    check("t1_first_scan_an", {12'd0, an}, 16'h000E);
    adjust_to(12, 34);
    pulse(BPAUSE);
    check("t1_run_count", count, 16'h1234);
    check("t1_run_state", {14'd0, state}, 16'h0001);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("t1_async_count", count, 16'h0000);
    check("t1_async_state", {14'd0, state}, 16'h0000);
    check("t1_async_an", {12'd0, an}, 16'h000F);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // T2 run and rollover
    adjust_to(58, 58);
    pulse(BPAUSE);
    check("t2_state_run", {14'd0, state}, 16'h0001);
    for (int i = 1; i <= 62; i++) begin
      pulse(B1HZ);
      if (i == 1)  check("t2_5859", count, 16'h5859);
      if (i == 2)  check("t2_5900", count, 16'h5900);
      if (i == 61) check("t2_5959", count, 16'h5959);
      if (i == 62) check("t2_0000", count, 16'h0000);
    end

    // T3 simultaneous 1 Hz and pause
    adjust_to(0, 5);
    pulse(BPAUSE);
    pulse(B1HZ | BPAUSE);
    check("t3_count", count, 16'h0006);
    check("t3_state", {14'd0, state}, 16'h0002);
    repeat (3) pulse(B1HZ);
    check("t3_hold", count, 16'h0006);

    // T4 minute adjust and blanking
    adjust_to(58, 30);
    sw_adj = 1'b1;
    sw_sel = 1'b1;
    @(negedge clk);
    pulse(B2HZ);
    check("t4_5930", count, 16'h5930);
    pulse(B2HZ);
    check("t4_0030", count, 16'h0030);
    pulse(B2HZ);
    check("t4_0130", count, 16'h0130);
    blanks = 0;
    repeat (4) begin
      pulse(B500);
      if (an == 4'b1111) blanks++;
    end
    check("t4_blanks", 16'(blanks), 16'd2);
    sw_adj = 1'b0;
    @(negedge clk);
    check("t4_pause", {14'd0, state}, 16'h0002);

    // T5 reset pulse priority
    sw_adj = 1'b1;
    @(negedge clk);
    pulse(BRST | BPAUSE);
    check("t5_idle", {14'd0, state}, 16'h0000);
    check("t5_count", count, 16'h0000);
    @(negedge clk);
    check("t5_adjust", {14'd0, state}, 16'h0003);
    sw_adj = 1'b0;
    sw_sel = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // T6 scan order from a fresh reset
    #2 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      pulse(B500);
      check("t6_an", {12'd0, an}, {12'd0, an_tbl[i % 4]});
      check("t6_digit", {12'd0, digit}, 16'h0000);
    end

    // Random stimulus against the model
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 2) == 0) ins[b] = ~ins[b];
      if ($urandom_range(0, 7) == 0)   ins[3] = ~ins[3];
      if ($urandom_range(0, 59) == 0)  ins[4] = ~ins[4];
      if ($urandom_range(0, 23) == 0)  sw_adj = ~sw_adj;
      if ($urandom_range(0, 9) == 0)   sw_sel = ~sw_sel;
      if ($urandom_range(0, 999) == 0) begin
        #2 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
